// File: rtl/pixel_plot_sink.sv
// Pixel-plot stream sink: range-checks (x,y), linearises to a 160x120 frame-buffer
// address, buffers pixels in a small FIFO and writes them out when the port is granted.
module pixel_plot_sink #(
    parameter int X_SCREEN_PIXELS = 160,
    parameter int Y_SCREEN_PIXELS = 120,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        plot,
    input  logic [7:0]  x,
    input  logic [6:0]  y,
    input  logic [2:0]  colour,
    output logic        ready,
    input  logic        fb_grant,
    output logic [14:0] fb_address,
    output logic [2:0]  fb_data,
    output logic        fb_wren,
    output logic [7:0]  oob_count,
    output logic        idle
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {W_IDLE, W_WAIT, W_WRITE} wstate_t;

    logic [14:0]   addr_mem [FIFO_DEPTH];
    logic [2:0]    col_mem  [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, count_next;
    wstate_t       state;

    logic        in_range, push, pop, oob_hit;
    logic [14:0] pix_addr;

    // ready comes from registered count only, so grant/plot never reach it combinationally
    assign ready      = (count != CW'(FIFO_DEPTH));
    assign in_range   = (x < 8'(X_SCREEN_PIXELS)) && (y < 7'(Y_SCREEN_PIXELS));
    assign pix_addr   = ({8'b0, y} << 7) + ({8'b0, y} << 5) + {7'b0, x};
    assign push       = plot && ready && in_range;
    assign oob_hit    = plot && ready && !in_range;
    assign pop        = (count != '0) && fb_grant;
    assign count_next = count + CW'(push) - CW'(pop);
    assign idle       = (state == W_IDLE);

    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr] <= pix_addr;
            col_mem[wr_ptr]  <= colour;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            state      <= W_IDLE;
            fb_wren    <= 1'b0;
            fb_address <= '0;
            fb_data    <= '0;
            oob_count  <= '0;
        end else begin
            count   <= count_next;
            fb_wren <= pop;
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr     <= rd_ptr + 1'b1;
                fb_address <= addr_mem[rd_ptr];
                fb_data    <= col_mem[rd_ptr];
            end
            if (oob_hit && oob_count != 8'hFF)
                oob_count <= oob_count + 8'd1;

            // W_IDLE doubles as the drain flag: nothing buffered and no write this cycle
            case (state)
                W_IDLE, W_WAIT, W_WRITE: begin
                    if (pop)
                        state <= W_WRITE;
                    else if (count_next != '0)
                        state <= W_WAIT;
                    else
                        state <= W_IDLE;
                end
                default: state <= W_IDLE;
            endcase
        end
    end
endmodule
